mm_reg_arb: RTL and testbench
=============================

MM_REG_ARB -- requirements
Module: mm_reg_arb

Interface
REQ-001 Parameter pNUM_REQ, default 4, SHALL set the number of MM requesters (2..8).
REQ-002 Parameter pRD_TIMEOUT, default 16'd1024, SHALL set the cycles allowed in WAIT_RD before a read times out (>=2).
REQ-003 Parameter pTIMEOUT_DATA, default 64'hDEAD_DEAD_DEAD_DEAD, SHALL set the read data returned on timeout.
REQ-004 Ports SHALL be:
  iCLK_100M  in  1  sole clock;
  iRST_100M  in  1  reset; one clock; reset is synchronous and active-high;
  iREQ_WR_EN  in  pNUM_REQ  per-requester write request, held until ack;
  iREQ_RD_EN  in  pNUM_REQ  per-requester read request, held until ack;
  iREQ_ADDRESS  in  pNUM_REQ x 10  per-requester register address;
  iREQ_WR_DATA  in  pNUM_REQ x 64  per-requester write data;
  oREQ_ACK  out  pNUM_REQ  one-hot one-cycle command-accepted pulse;
  oREQ_RD_DATA  out  64  read data, shared by all requesters;
  oREQ_RD_DATA_V  out  pNUM_REQ  one-hot one-cycle read-data-valid pulse;
  oMM_WR_EN  out  1  write strobe to the register block;
  oMM_RD_EN  out  1  read strobe to the register block;
  oMM_ADDRESS  out  10  register address;
  oMM_WR_DATA  out  64  register write data;
  iMM_RD_DATA  in  64  register read data;
  iMM_RD_DATA_V  in  1  register read-data valid;
  oRD_TIMEOUT  out  1  one-cycle pulse on read timeout;
  oTIMEOUT_CNT  out  8  saturating count of read timeouts.

Function
REQ-005 The FSM SHALL have four states: IDLE, ISSUE, WAIT_RD and RESP.
REQ-006 In IDLE with any request bit set, the block SHALL grant one requester round-robin, searching from last_grant+1 with wrap-around.
REQ-007 On a grant it SHALL register that requester's address, data and command, then go to ISSUE.
REQ-008 A requester asserting both iREQ_WR_EN and iREQ_RD_EN SHALL be served as a write only, and the read SHALL be dropped.
REQ-009 In ISSUE the block SHALL assert exactly one of oMM_WR_EN/oMM_RD_EN for one cycle.
  - oREQ_ACK[grant] SHALL pulse in the same cycle.
  - last_grant SHALL update in the same cycle.
REQ-010 Transitions out of ISSUE SHALL be: write -> IDLE; read -> WAIT_RD with the timer cleared.
  - Write throughput SHALL be one write per 2 cycles.
REQ-011 iMM_RD_DATA_V SHALL be sampled only in WAIT_RD; in any other state it SHALL be ignored.
REQ-012 In WAIT_RD, iMM_RD_DATA_V=1 SHALL capture iMM_RD_DATA into oREQ_RD_DATA and go to RESP.
REQ-013 In WAIT_RD, if the timer reaches pRD_TIMEOUT-1 without valid data, the block SHALL:
  - load pTIMEOUT_DATA into oREQ_RD_DATA;
  - pulse oRD_TIMEOUT;
  - increment oTIMEOUT_CNT, saturating at 8'hFF;
  - go to RESP.
REQ-014 If iMM_RD_DATA_V and timer expiry coincide, the data SHALL win and no timeout SHALL be recorded.
REQ-015 In RESP, oREQ_RD_DATA_V[grant] SHALL pulse for one cycle, then the FSM SHALL return to IDLE.
REQ-016 oREQ_RD_DATA SHALL hold its value until the next capture.
REQ-017 Read latency from the ISSUE cycle SHALL be slave latency + 1 cycle to oREQ_RD_DATA_V.
REQ-018 Requests deasserted before ack SHALL NOT be issued; requests arriving outside IDLE SHALL wait.
REQ-019 With all requesters continuously requesting, no requester SHALL wait more than pNUM_REQ-1 grants.

Reset
REQ-020 While iRST_100M=1 at a clock edge, the block SHALL set:
  - state=IDLE;
  - last_grant=pNUM_REQ-1, so requester 0 wins first;
  - all strobes, ack, valid and oRD_TIMEOUT to 0;
  - oMM_ADDRESS, oMM_WR_DATA and oREQ_RD_DATA to 0;
  - timer and oTIMEOUT_CNT to 0.
REQ-021 Reset asserted mid-transaction SHALL abandon the transaction without emitting ack or valid, and a late iMM_RD_DATA_V after reset SHALL be ignored.

Structure
REQ-022 A package mm_arb_pkg SHALL hold the FSM state enum, the MM address/data width constants and the default timeout data constant.
REQ-023 The round-robin grant logic SHALL be a sub-module rr_arb: request vector plus last_grant in, one-hot grant plus valid out, purely combinational.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
  - Single write: requester 1 writes addr 10'd17, data 64'h5F5E100 -> oMM_WR_EN one cycle with those values; oREQ_ACK=4'b0010 in the same cycle; back in IDLE 2 cycles after the request.
  - Contention: all 4 request reads after reset, slave answers 1 cycle after rd_en -> grant order 0,1,2,3; each oREQ_RD_DATA_V one-hot to the matching requester.
  - Timeout: pRD_TIMEOUT=8, slave never answers -> after 8 WAIT_RD cycles, oREQ_RD_DATA=64'hDEADDEADDEADDEAD, oRD_TIMEOUT pulse, oTIMEOUT_CNT=1.
  - Collision: iMM_RD_DATA_V arrives on the expiry cycle with data 64'h1234 -> data 64'h1234 returned; oRD_TIMEOUT=0; count unchanged.
  - Reset: reset asserted in WAIT_RD, slave valid arrives 2 cycles later -> no oREQ_RD_DATA_V; next grant goes to requester 0.
  - Saturation and strays: 300 timeouts -> oTIMEOUT_CNT=8'hFF; rd+wr from one requester -> write only; stray iMM_RD_DATA_V in IDLE -> no output.

Source files
------------

// File: rtl/mm_arb_pkg.sv
// Shared types and constants for the memory-mapped register arbiter.
package mm_arb_pkg;

  localparam int MM_ADDR_W = 10;
  localparam int MM_DATA_W = 64;

  // Read data returned to a requester when the register block never answers.
  localparam logic [MM_DATA_W-1:0] DEFAULT_TIMEOUT_DATA = 64'hDEAD_DEAD_DEAD_DEAD;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_RESP    = 2'd3
  } arb_state_e;

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin picker: searches from last_grant+1 upward,
// wrapping to 0, and returns a one-hot grant plus a valid flag.
module rr_arb #(
  parameter int N   = 4,
  parameter int LGW = 2
) (
  input  logic [N-1:0]   i_req,
  input  logic [LGW-1:0] i_last_grant,
  output logic [N-1:0]   o_grant,
  output logic           o_valid
);

  // First pass covers indices above last_grant, second pass wraps to the bottom.
  always_comb begin
    o_grant = '0;
    o_valid = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!o_valid && i_req[j] && (j > int'(i_last_grant))) begin
        o_grant[j] = 1'b1;
        o_valid    = 1'b1;
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!o_valid && i_req[j] && (j <= int'(i_last_grant))) begin
        o_grant[j] = 1'b1;
        o_valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mm_reg_arb.sv
// Arbitrates several memory-mapped requesters onto one register block port.
//
// Handshake: a requester raises iREQ_WR_EN or iREQ_RD_EN (with address/data
// stable) and holds it until it sees oREQ_ACK for its index; the ack cycle is
// the cycle the command is driven to the register block. A read completes
// later with a one-cycle oREQ_RD_DATA_V pulse for the same index. The register
// block answers a read strobe with iMM_RD_DATA_V at least one cycle later; if
// no answer arrives within pRD_TIMEOUT cycles a fixed pattern is returned.
module mm_reg_arb
  import mm_arb_pkg::*;
#(
  parameter int                   pNUM_REQ      = 4,
  parameter logic [15:0]          pRD_TIMEOUT   = 16'd1024,
  parameter logic [MM_DATA_W-1:0] pTIMEOUT_DATA = DEFAULT_TIMEOUT_DATA
) (
  input  logic                                 iCLK_100M,
  input  logic                                 iRST_100M,
  input  logic [pNUM_REQ-1:0]                  iREQ_WR_EN,
  input  logic [pNUM_REQ-1:0]                  iREQ_RD_EN,
  input  logic [pNUM_REQ-1:0][MM_ADDR_W-1:0]   iREQ_ADDRESS,
  input  logic [pNUM_REQ-1:0][MM_DATA_W-1:0]   iREQ_WR_DATA,
  output logic [pNUM_REQ-1:0]                  oREQ_ACK,
  output logic [MM_DATA_W-1:0]                 oREQ_RD_DATA,
  output logic [pNUM_REQ-1:0]                  oREQ_RD_DATA_V,
  output logic                                 oMM_WR_EN,
  output logic                                 oMM_RD_EN,
  output logic [MM_ADDR_W-1:0]                 oMM_ADDRESS,
  output logic [MM_DATA_W-1:0]                 oMM_WR_DATA,
  input  logic [MM_DATA_W-1:0]                 iMM_RD_DATA,
  input  logic                                 iMM_RD_DATA_V,
  output logic                                 oRD_TIMEOUT,
  output logic [7:0]                           oTIMEOUT_CNT
);

  localparam int LGW = $clog2(pNUM_REQ);

  arb_state_e                r_state;
  logic [LGW-1:0]            r_last_grant;
  logic [pNUM_REQ-1:0]       r_grant;
  logic                      r_is_wr;
  logic [15:0]               r_timer;
  logic [pNUM_REQ-1:0]       r_ack;
  logic [pNUM_REQ-1:0]       r_rd_data_v;
  logic                      r_mm_wr_en;
  logic                      r_mm_rd_en;
  logic [MM_ADDR_W-1:0]      r_mm_addr;
  logic [MM_DATA_W-1:0]      r_mm_wr_data;
  logic [MM_DATA_W-1:0]      r_rd_data;
  logic                      r_rd_timeout;
  logic [7:0]                r_timeout_cnt;

  logic [pNUM_REQ-1:0]       w_req;
  logic [pNUM_REQ-1:0]       w_grant;
  logic                      w_grant_valid;
  logic [LGW-1:0]            w_grant_idx;
  logic [MM_ADDR_W-1:0]      w_sel_addr;
  logic [MM_DATA_W-1:0]      w_sel_data;
  logic                      w_sel_wr;

  // A requester is pending if it asks for either command.
  assign w_req = iREQ_WR_EN | iREQ_RD_EN;

  rr_arb #(
    .N   (pNUM_REQ),
    .LGW (LGW)
  ) u_rr_arb (
    .i_req        (w_req),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_valid      (w_grant_valid)
  );

  // Select the granted requester's address/data and turn the one-hot grant into an index.
  always_comb begin
    w_grant_idx = '0;
    w_sel_addr  = '0;
    w_sel_data  = '0;
    for (int i = 0; i < pNUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_grant_idx = LGW'(i);
        w_sel_addr  = iREQ_ADDRESS[i];
        w_sel_data  = iREQ_WR_DATA[i];
      end
    end
  end

  // Write wins over read when a requester raises both; the read is dropped.
  assign w_sel_wr = |(w_grant & iREQ_WR_EN);

  // Arbiter FSM; every output is a register loaded on the edge entering its state.
  always_ff @(posedge iCLK_100M) begin
    if (iRST_100M) begin
      r_state       <= ST_IDLE;
      r_last_grant  <= LGW'(pNUM_REQ - 1);
      r_grant       <= '0;
      r_is_wr       <= 1'b0;
      r_timer       <= '0;
      r_ack         <= '0;
      r_rd_data_v   <= '0;
      r_mm_wr_en    <= 1'b0;
      r_mm_rd_en    <= 1'b0;
      r_mm_addr     <= '0;
      r_mm_wr_data  <= '0;
      r_rd_data     <= '0;
      r_rd_timeout  <= 1'b0;
      r_timeout_cnt <= '0;
    end else begin
      r_ack        <= '0;
      r_rd_data_v  <= '0;
      r_mm_wr_en   <= 1'b0;
      r_mm_rd_en   <= 1'b0;
      r_rd_timeout <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_grant_valid) begin
            r_grant      <= w_grant;
            r_last_grant <= w_grant_idx;
            r_is_wr      <= w_sel_wr;
            r_mm_addr    <= w_sel_addr;
            r_mm_wr_data <= w_sel_data;
            r_mm_wr_en   <= w_sel_wr;
            r_mm_rd_en   <= !w_sel_wr;
            r_ack        <= w_grant;
            r_state      <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (r_is_wr) begin
            r_state <= ST_IDLE;
          end else begin
            r_timer <= '0;
            r_state <= ST_WAIT_RD;
          end
        end
        ST_WAIT_RD: begin
          // Valid data takes priority over an expiry landing in the same cycle.
          if (iMM_RD_DATA_V) begin
            r_rd_data   <= iMM_RD_DATA;
            r_rd_data_v <= r_grant;
            r_state     <= ST_RESP;
          end else if (r_timer == (pRD_TIMEOUT - 16'd1)) begin
            r_rd_data    <= pTIMEOUT_DATA;
            r_rd_data_v  <= r_grant;
            r_rd_timeout <= 1'b1;
            if (r_timeout_cnt != 8'hFF) begin
              r_timeout_cnt <= r_timeout_cnt + 8'd1;
            end
            r_state <= ST_RESP;
          end else begin
            r_timer <= r_timer + 16'd1;
          end
        end
        ST_RESP: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign oREQ_ACK       = r_ack;
  assign oREQ_RD_DATA   = r_rd_data;
  assign oREQ_RD_DATA_V = r_rd_data_v;
  assign oMM_WR_EN      = r_mm_wr_en;
  assign oMM_RD_EN      = r_mm_rd_en;
  assign oMM_ADDRESS    = r_mm_addr;
  assign oMM_WR_DATA    = r_mm_wr_data;
  assign oRD_TIMEOUT    = r_rd_timeout;
  assign oTIMEOUT_CNT   = r_timeout_cnt;

endmodule

// File: tb/tb_mm_reg_arb.sv
// Bench for mm_reg_arb: directed scenarios followed by randomized traffic,
// checked against a transaction-level model of arbitration and read results.
module tb_mm_reg_arb;

  localparam int          NREQ      = 4;
  localparam int          TO_CYCLES = 8;
  localparam logic [63:0] TO_DATA   = 64'hDEAD_DEAD_DEAD_DEAD;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT connections ----------------
  logic [NREQ-1:0]        req_wr_en;
  logic [NREQ-1:0]        req_rd_en;
  logic [NREQ-1:0][9:0]   req_addr;
  logic [NREQ-1:0][63:0]  req_wdata;
  logic [NREQ-1:0]        ack;
  logic [63:0]            rd_data;
  logic [NREQ-1:0]        rd_data_v;
  logic                   mm_wr_en;
  logic                   mm_rd_en;
  logic [9:0]             mm_addr;
  logic [63:0]            mm_wr_data;
  logic [63:0]            mm_rd_data;
  logic                   mm_rd_data_v;
  logic                   rd_timeout;
  logic [7:0]             timeout_cnt;

  mm_reg_arb #(
    .pNUM_REQ    (NREQ),
    .pRD_TIMEOUT (16'(TO_CYCLES))
  ) dut (
    .iCLK_100M      (clk),
    .iRST_100M      (rst),
    .iREQ_WR_EN     (req_wr_en),
    .iREQ_RD_EN     (req_rd_en),
    .iREQ_ADDRESS   (req_addr),
    .iREQ_WR_DATA   (req_wdata),
    .oREQ_ACK       (ack),
    .oREQ_RD_DATA   (rd_data),
    .oREQ_RD_DATA_V (rd_data_v),
    .oMM_WR_EN      (mm_wr_en),
    .oMM_RD_EN      (mm_rd_en),
    .oMM_ADDRESS    (mm_addr),
    .oMM_WR_DATA    (mm_wr_data),
    .iMM_RD_DATA    (mm_rd_data),
    .iMM_RD_DATA_V  (mm_rd_data_v),
    .oRD_TIMEOUT    (rd_timeout),
    .oTIMEOUT_CNT   (timeout_cnt)
  );

  // ---------------- model state and scoreboard ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  int          model_last;
  int          model_cnt;
  logic [63:0] last_rd;
  logic [63:0] exp_q[$];
  int          lat[NREQ];
  logic [63:0] rdat[NREQ];
  bit          arrivals_en = 1'b0;
  bit          flash_en    = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Next requester after 'last' (wrapping) that has a request pending.
  function automatic int model_pick(input logic [NREQ-1:0] pend, input int last);
    int idx;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (last + k) % NREQ;
      if (pend[idx[1:0]]) return idx;
    end
    return -1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // cmd: 0 write, 1 read, 2 both raised (served as a write)
  task automatic load_req(input logic [1:0] j, input int cmd, input logic [9:0] a,
                          input logic [63:0] d, input int l, input logic [63:0] r);
    req_wr_en[j] = (cmd != 1);
    req_rd_en[j] = (cmd != 0);
    req_addr[j]  = a;
    req_wdata[j] = d;
    lat[j]       = l;
    rdat[j]      = r;
  endtask

  task automatic do_reset();
    rst          = 1'b1;
    req_wr_en    = '0;
    req_rd_en    = '0;
    mm_rd_data_v = 1'b0;
    mm_rd_data   = '0;
    tick();
    tick();
    check("rst_ack", ack, 0);
    check("rst_rd_v", rd_data_v, 0);
    check("rst_strobes", {mm_wr_en, mm_rd_en}, 0);
    check("rst_addr", mm_addr, 0);
    check("rst_wdata", mm_wr_data, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_timeout", rd_timeout, 0);
    check("rst_cnt", timeout_cnt, 0);
    rst        = 1'b0;
    model_last = NREQ - 1;
    model_cnt  = 0;
    last_rd    = '0;
    exp_q.delete();
  endtask

  // Serve one transaction; DUT must be in IDLE with requests already driven.
  task automatic serve_one(output int g);
    logic [NREQ-1:0] pend;
    logic [1:0]      gi;
    logic [1:0]      nj;
    logic            is_wr;
    logic            to;
    int              l;
    int              eff;
    logic [63:0]     rd_val;
    logic [63:0]     exp_d;
    pend   = req_wr_en | req_rd_en;
    g      = model_pick(pend, model_last);
    gi     = g[1:0];
    is_wr  = req_wr_en[gi];
    l      = lat[gi];
    rd_val = rdat[gi];
    tick();
    check("issue_ack", ack, 4'b0001 << gi);
    check("issue_wr_en", mm_wr_en, is_wr);
    check("issue_rd_en", mm_rd_en, !is_wr);
    check("issue_addr", mm_addr, req_addr[gi]);
    if (is_wr) check("issue_wdata", mm_wr_data, req_wdata[gi]);
    req_wr_en[gi] = 1'b0;
    req_rd_en[gi] = 1'b0;
    model_last    = g;
    if (is_wr) begin
      tick();
      check("wr_done_ack", ack, 0);
      check("wr_done_strobe", {mm_wr_en, mm_rd_en}, 0);
      return;
    end
    to    = (l > TO_CYCLES);
    exp_d = to ? TO_DATA : rd_val;
    exp_q.push_back(exp_d);
    eff   = to ? TO_CYCLES : l;
    for (int k = 1; k <= eff; k++) begin
      tick();
      mm_rd_data_v = (k == l);
      mm_rd_data   = (k == l) ? rd_val : {$urandom, $urandom};
      if (arrivals_en && k == 1 && $urandom_range(0, 2) == 0) begin
        nj = 2'($urandom_range(0, NREQ - 1));
        if (!(req_wr_en[nj] | req_rd_en[nj]))
          load_req(nj, $urandom_range(0, 2), 10'($urandom), {$urandom, $urandom},
                   $urandom_range(1, 10), {$urandom, $urandom});
      end
      if (flash_en && k == 2) req_wr_en[1] = 1'b1;
      if (flash_en && k == 5) req_wr_en[1] = 1'b0;
      check("wait_no_valid", rd_data_v, 0);
      check("wait_no_timeout", rd_timeout, 0);
      check("wait_no_strobe", {mm_wr_en, mm_rd_en}, 0);
    end
    tick();
    mm_rd_data_v = 1'b0;
    if (to && model_cnt < 255) model_cnt++;
    check("resp_valid", rd_data_v, 4'b0001 << gi);
    check("resp_data", rd_data, exp_q.pop_front());
    check("resp_timeout", rd_timeout, to);
    check("resp_cnt", timeout_cnt, model_cnt);
    last_rd = exp_d;
    tick();
    check("resp_done_valid", rd_data_v, 0);
    check("resp_done_timeout", rd_timeout, 0);
    check("resp_hold_data", rd_data, last_rd);
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    int g;
    int guard;
    logic [NREQ-1:0] mask;
    rst          = 1'b1;
    req_wr_en    = '0;
    req_rd_en    = '0;
    req_addr     = '0;
    req_wdata    = '0;
    mm_rd_data   = '0;
    mm_rd_data_v = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      lat[i]  = 1;
      rdat[i] = '0;
    end
    do_reset();

    // Single write from requester 1, then back-to-back write from requester 2.
    load_req(2'd1, 0, 10'd17, 64'h5F5E100, 1, '0);
    serve_one(g);
    check("single_wr_grant", 64'(g), 1);
    load_req(2'd2, 0, 10'd300, 64'hA5A5_0000_1111_2222, 1, '0);
    serve_one(g);
    check("b2b_wr_grant", 64'(g), 2);

    // Contention: four reads after reset, slave answers one cycle after rd_en.
    do_reset();
    for (int i = 0; i < NREQ; i++)
      load_req(2'(i), 1, 10'(100 + i), '0, 1, 64'h1000 + 64'(i));
    for (int i = 0; i < NREQ; i++) begin
      serve_one(g);
      check("rr_order", 64'(g), 64'(i));
    end

    // Timeout with a request raised and dropped before it could be acked.
    load_req(2'd0, 1, 10'd5, '0, 99, '0);
    flash_en = 1'b1;
    serve_one(g);
    flash_en = 1'b0;
    check("to_cnt_one", timeout_cnt, 8'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("dropped_req_no_ack", ack, 0);
      check("dropped_req_no_strobe", {mm_wr_en, mm_rd_en}, 0);
    end

    // Valid on the expiry cycle: data wins, no timeout recorded.
    load_req(2'd3, 1, 10'd6, '0, TO_CYCLES, 64'h1234);
    serve_one(g);
    check("collision_cnt", timeout_cnt, 8'd1);

    // Stray slave valid in IDLE must not produce anything.
    for (int i = 0; i < 3; i++) begin
      mm_rd_data_v = 1'b1;
      mm_rd_data   = {$urandom, $urandom};
      tick();
      check("stray_no_valid", rd_data_v, 0);
      check("stray_hold_data", rd_data, last_rd);
      check("stray_no_ack", ack, 0);
    end
    mm_rd_data_v = 1'b0;

    // Read and write together from one requester: write only.
    load_req(2'd2, 2, 10'd77, 64'hCAFE_F00D, 1, 64'hBAD);
    serve_one(g);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rdwr_no_rd_en", mm_rd_en, 0);
      check("rdwr_no_ack", ack, 0);
    end

    // Reset during WAIT_RD, late slave valid two cycles after reset.
    load_req(2'd2, 1, 10'd9, '0, 99, '0);
    tick();
    check("midrst_issue_ack", ack, 4'b0100);
    req_rd_en[2] = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    model_last = NREQ - 1;
    model_cnt  = 0;
    last_rd    = '0;
    tick();
    mm_rd_data_v = 1'b1;
    mm_rd_data   = 64'hBAD0_BAD0;
    tick();
    mm_rd_data_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("midrst_no_valid", rd_data_v, 0);
      check("midrst_no_ack", ack, 0);
      check("midrst_rd_data", rd_data, 0);
      check("midrst_cnt", timeout_cnt, 0);
      tick();
    end
    load_req(2'd1, 0, 10'd11, 64'h11, 1, '0);
    load_req(2'd0, 1, 10'd10, '0, 2, 64'h77);
    serve_one(g);
    check("post_rst_grant0", 64'(g), 0);
    serve_one(g);
    check("post_rst_grant1", 64'(g), 1);

    // Randomized rounds with arrivals during busy states.
    arrivals_en = 1'b1;
    for (int r = 0; r < 16; r++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < NREQ; i++)
        if (mask[i])
          load_req(2'(i), $urandom_range(0, 2), 10'($urandom), {$urandom, $urandom},
                   $urandom_range(1, 10), {$urandom, $urandom});
      guard = 0;
      while ((req_wr_en | req_rd_en) != 0 && guard < 64) begin
        serve_one(g);
        guard++;
      end
      check("rand_drained", 64'(req_wr_en | req_rd_en), 0);
    end
    arrivals_en = 1'b0;

    // Saturation: 300 timeouts.
    for (int i = 0; i < 300; i++) begin
      load_req(2'(i % NREQ), 1, 10'(i), '0, 99, '0);
      serve_one(g);
    end
    check("sat_cnt", timeout_cnt, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
